// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode stage: field positions,
// the decoded-entry record and the skid-buffer occupancy encoding.
package decode_pkg;

   localparam int OPCODE_LSB = 24;
   localparam int RD_LSB     = 16;
   localparam int RT_LSB     = 8;
   localparam int RS_LSB     = 0;
   localparam int FIELD_W    = 8;

   localparam logic [31:0] PC_INCR = 32'd4;

   // Fields are held at their widest legal size; the top trims them to the
   // configured register-address and PC widths.
   typedef struct packed {
      logic [7:0]  opcode;
      logic [7:0]  rd;
      logic [7:0]  rt;
      logic [7:0]  rs;
      logic [7:0]  imm;
      logic [7:0]  offset;
      logic [31:0] target;
      logic        illegal;
      logic [31:0] pc;
   } decode_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_e;

   function automatic logic [7:0] field_mask(input int w);
      logic [8:0] m;
      m = 9'd1 << w;
      return 8'(m - 9'd1);
   endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into its fields plus the
// precomputed branch target and the out-of-range register flag.
module instr_field_decode
   import decode_pkg::*;
#(
   parameter int REG_ADDR_W      = 3,
   parameter int PC_W            = 32,
   parameter bit SIGN_EXT_OFFSET = 1'b1
) (
   input  logic [31:0]     instruction,
   input  logic [PC_W-1:0] pc_in,
   output decode_entry_t   entry
);

   localparam logic [7:0]  REG_MASK = field_mask(REG_ADDR_W);
   localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFF >> (32 - PC_W);

   logic [7:0]  rd_byte;
   logic [7:0]  rt_byte;
   logic [7:0]  rs_byte;
   logic [31:0] pc_ext;
   logic [31:0] off_ext;
   logic [31:0] sum;

   always_comb begin
      rd_byte = instruction[RD_LSB +: FIELD_W];
      rt_byte = instruction[RT_LSB +: FIELD_W];
      rs_byte = instruction[RS_LSB +: FIELD_W];
      pc_ext  = 32'(pc_in);
      off_ext = SIGN_EXT_OFFSET ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      // 32-bit sum then masked, which equals wrapping modulo 2^PC_W
      sum     = pc_ext + PC_INCR + (off_ext << 2);

      entry         = '0;
      entry.opcode  = instruction[OPCODE_LSB +: FIELD_W];
      entry.rd      = rd_byte & REG_MASK;
      entry.rt      = rt_byte & REG_MASK;
      entry.rs      = rs_byte & REG_MASK;
      entry.imm     = rs_byte;
      entry.offset  = rd_byte;
      entry.target  = sum & PC_MASK;
      entry.illegal = |((rd_byte | rt_byte | rs_byte) & ~REG_MASK);
      entry.pc      = pc_ext;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decode at accept, two-entry skid buffer with a
// registered ready, synchronous flush.
//
// state     | meaning
// OCC_EMPTY | no beat held, out_valid low
// OCC_ONE   | main entry holds the presented beat
// OCC_FULL  | main presented, skid holds the next beat, in_ready low
module instr_decode_stage
   import decode_pkg::*;
#(
   parameter int REG_ADDR_W      = 3,
   parameter int PC_W            = 32,
   parameter bit SIGN_EXT_OFFSET = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instruction,
   input  logic [PC_W-1:0]       pc_in,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            opcode,
   output logic [REG_ADDR_W-1:0] writereg,
   output logic [REG_ADDR_W-1:0] readreg1,
   output logic [REG_ADDR_W-1:0] readreg2,
   output logic [7:0]            immediate,
   output logic [7:0]            offset,
   output logic [PC_W-1:0]       branch_target,
   output logic                  illegal_reg,
   output logic [PC_W-1:0]       pc_out
);

   occ_state_e    state, state_nxt;
   logic          in_ready_q, in_ready_nxt;
   decode_entry_t main_q, main_nxt;
   decode_entry_t skid_q, skid_nxt;
   decode_entry_t dec;
   logic          accept;
   logic          present;

   instr_field_decode #(
      .REG_ADDR_W      (REG_ADDR_W),
      .PC_W            (PC_W),
      .SIGN_EXT_OFFSET (SIGN_EXT_OFFSET)
   ) u_field_decode (
      .instruction (instruction),
      .pc_in       (pc_in),
      .entry       (dec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= OCC_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state      <= state_nxt;
         in_ready_q <= in_ready_nxt;
         main_q     <= main_nxt;
         skid_q     <= skid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      accept    = in_valid & in_ready_q & ~flush;
      present   = (state != OCC_EMPTY) & out_ready;

      case (state)
         OCC_EMPTY: begin
            if (accept) begin
               main_nxt  = dec;
               state_nxt = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (accept && present) begin
               main_nxt = dec;
            end else if (accept) begin
               skid_nxt  = dec;
               state_nxt = OCC_FULL;
            end else if (present) begin
               state_nxt = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (present) begin
               main_nxt  = skid_q;
               state_nxt = OCC_ONE;
            end
         end
         default: state_nxt = OCC_EMPTY;
      endcase

      // Held data is left in place; out_valid low makes it invisible.
      if (flush) state_nxt = OCC_EMPTY;

      in_ready_nxt = (state_nxt != OCC_FULL);
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = (state != OCC_EMPTY);
   assign opcode        = main_q.opcode;
   assign writereg      = main_q.rd[REG_ADDR_W-1:0];
   assign readreg1      = main_q.rt[REG_ADDR_W-1:0];
   assign readreg2      = main_q.rs[REG_ADDR_W-1:0];
   assign immediate     = main_q.imm;
   assign offset        = main_q.offset;
   assign branch_target = main_q.target[PC_W-1:0];
   assign illegal_reg   = main_q.illegal;
   assign pc_out        = main_q.pc[PC_W-1:0];

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: two configurations driven by shared stimulus,
// directed steps followed by a random phase against a queue-based model.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        flush;
   logic        out_ready;
   logic [31:0] instruction;
   logic [31:0] pc_in;

   logic        a_in_ready, a_out_valid, a_illegal;
   logic [7:0]  a_opcode, a_imm, a_offset;
   logic [2:0]  a_wr, a_r1, a_r2;
   logic [31:0] a_target, a_pc;

   logic        b_in_ready, b_out_valid, b_illegal;
   logic [7:0]  b_opcode, b_imm, b_offset;
   logic [7:0]  b_wr, b_r1, b_r2;
   logic [31:0] b_target, b_pc;

   always #5 clk = ~clk;

   instr_decode_stage #(.REG_ADDR_W(3), .PC_W(32), .SIGN_EXT_OFFSET(1'b1)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .instruction(instruction), .pc_in(pc_in), .flush(flush),
      .out_valid(a_out_valid), .out_ready(out_ready), .opcode(a_opcode),
      .writereg(a_wr), .readreg1(a_r1), .readreg2(a_r2), .immediate(a_imm),
      .offset(a_offset), .branch_target(a_target), .illegal_reg(a_illegal),
      .pc_out(a_pc)
   );

   instr_decode_stage #(.REG_ADDR_W(8), .PC_W(32), .SIGN_EXT_OFFSET(1'b0)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .instruction(instruction), .pc_in(pc_in), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready), .opcode(b_opcode),
      .writereg(b_wr), .readreg1(b_r1), .readreg2(b_r2), .immediate(b_imm),
      .offset(b_offset), .branch_target(b_target), .illegal_reg(b_illegal),
      .pc_out(b_pc)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } beat_t;

   beat_t         q[$];
   logic [31:0]   presented[$];
   bit            zeroed;
   bit            last_acc;
   int            total = 0;
   int            bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint ref_target(input logic [31:0] instr, input logic [31:0] pc,
                                         input bit sgn);
      longint o;
      o = longint'(instr[23:16]);
      if (sgn && o >= 128) o = o - 256;
      return (longint'(pc) + 4 + 4 * o) & 64'hFFFF_FFFF;
   endfunction

   function automatic longint ref_reg(input logic [7:0] b, input int w);
      return longint'(b) % (longint'(1) << w);
   endfunction

   function automatic bit ref_illegal(input logic [31:0] instr, input int w);
      longint lim;
      lim = longint'(1) << w;
      return (longint'(instr[23:16]) >= lim) || (longint'(instr[15:8]) >= lim) ||
             (longint'(instr[7:0]) >= lim);
   endfunction

   task automatic model_update();
      bit acc, pres;
      acc      = in_valid && (q.size() < 2) && !flush;
      pres     = (q.size() > 0) && out_ready;
      last_acc = 1'b0;
      if (reset) begin
         q.delete();
         zeroed = 1'b1;
      end else begin
         if (pres) presented.push_back(q[0].pc);
         if (flush) begin
            q.delete();
         end else begin
            if (pres) void'(q.pop_front());
            if (acc) begin
               q.push_back('{instruction, pc_in});
               zeroed   = 1'b0;
               last_acc = 1'b1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      beat_t e;
      chk("a.out_valid", a_out_valid, q.size() > 0);
      chk("a.in_ready", a_in_ready, q.size() < 2);
      chk("b.out_valid", b_out_valid, q.size() > 0);
      chk("b.in_ready", b_in_ready, q.size() < 2);
      if (q.size() > 0) begin
         e = q[0];
         chk("a.opcode", a_opcode, e.instr >> 24);
         chk("a.writereg", a_wr, ref_reg(e.instr[23:16], 3));
         chk("a.readreg1", a_r1, ref_reg(e.instr[15:8], 3));
         chk("a.readreg2", a_r2, ref_reg(e.instr[7:0], 3));
         chk("a.immediate", a_imm, e.instr & 32'hFF);
         chk("a.offset", a_offset, (e.instr >> 16) & 32'hFF);
         chk("a.target", a_target, ref_target(e.instr, e.pc, 1'b1));
         chk("a.illegal", a_illegal, ref_illegal(e.instr, 3));
         chk("a.pc_out", a_pc, e.pc);
         chk("b.writereg", b_wr, ref_reg(e.instr[23:16], 8));
         chk("b.readreg1", b_r1, ref_reg(e.instr[15:8], 8));
         chk("b.readreg2", b_r2, ref_reg(e.instr[7:0], 8));
         chk("b.target", b_target, ref_target(e.instr, e.pc, 1'b0));
         chk("b.illegal", b_illegal, 0);
         chk("b.pc_out", b_pc, e.pc);
      end else if (zeroed) begin
         chk("a.zero_data", {a_opcode, a_wr, a_r1, a_r2, a_imm, a_offset, a_illegal}, 0);
         chk("a.zero_target", a_target, 0);
         chk("a.zero_pc", a_pc, 0);
         chk("b.zero_data", {b_opcode, b_wr, b_r1, b_r2, b_imm, b_offset, b_illegal}, 0);
         chk("b.zero_target", b_target, 0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
      in_valid    = 1'b1;
      instruction = instr;
      pc_in       = pc;
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      instruction = '0;
      pc_in       = '0;
      zeroed      = 1'b1;
      @(negedge clk);
      cycle();
      cycle();
      chk("reset.in_ready", a_in_ready, 1);
      chk("reset.out_valid", a_out_valid, 0);
      reset = 1'b0;

      // basic decode
      offer(32'h0205_0301, 32'h100);
      cycle();
      chk("t1.out_valid", a_out_valid, 1);
      chk("t1.opcode", a_opcode, 8'h02);
      chk("t1.writereg", a_wr, 5);
      chk("t1.readreg1", a_r1, 3);
      chk("t1.readreg2", a_r2, 1);
      chk("t1.immediate", a_imm, 8'h01);
      chk("t1.target", a_target, 32'h118);
      chk("t1.illegal", a_illegal, 0);
      in_valid = 1'b0;
      cycle();

      // negative offset, sign vs zero extension
      offer(32'h00FE_0000, 32'h100);
      cycle();
      chk("t2.target_sext", a_target, 32'hFC);
      chk("t2.target_zext", b_target, 32'h4FC);
      in_valid = 1'b0;
      cycle();

      // out-of-range register field
      offer(32'h0009_0000, 32'h40);
      cycle();
      chk("t3.writereg_w3", a_wr, 1);
      chk("t3.illegal_w3", a_illegal, 1);
      chk("t3.writereg_w8", b_wr, 9);
      chk("t3.illegal_w8", b_illegal, 0);
      in_valid = 1'b0;
      cycle();

      // target wrap
      offer(32'h0, 32'hFFFF_FFFC);
      cycle();
      chk("t4.wrap_a", a_target, 0);
      chk("t4.wrap_b", b_target, 0);
      in_valid = 1'b0;
      cycle();

      // backpressure: A, B fill the buffer, C is held upstream
      out_ready = 1'b0;
      offer(32'h1100_0102, 32'h200);
      cycle();
      offer(32'h1201_0203, 32'h204);
      cycle();
      chk("t5.in_ready_after_b", a_in_ready, 0);
      offer(32'h1302_0304, 32'h208);
      cycle();
      chk("t5.hold_in_ready", a_in_ready, 0);
      chk("t5.hold_pc", a_pc, 32'h200);
      presented.delete();
      out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 10 && presented.size() < 3; i++) begin
         cycle();
         n++;
         if (last_acc) in_valid = 1'b0;
      end
      chk("t5.count", presented.size(), 3);
      chk("t5.cycles", n, 3);
      if (presented.size() == 3) begin
         chk("t5.order0", presented[0], 32'h200);
         chk("t5.order1", presented[1], 32'h204);
         chk("t5.order2", presented[2], 32'h208);
      end
      in_valid = 1'b0;
      cycle();

      // flush while full, offered beat is dropped
      out_ready = 1'b0;
      offer(32'h2000_0000, 32'h300);
      cycle();
      offer(32'h2100_0000, 32'h304);
      cycle();
      offer(32'h2200_0000, 32'h3F0);
      flush = 1'b1;
      cycle();
      chk("t6.out_valid", a_out_valid, 0);
      chk("t6.in_ready", a_in_ready, 1);
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      presented.delete();
      cycle();
      cycle();
      chk("t6.no_ghost", presented.size(), 0);

      // reset while full
      out_ready = 1'b0;
      offer(32'h3305_0607, 32'h500);
      cycle();
      offer(32'h3406_0708, 32'h504);
      cycle();
      in_valid = 1'b0;
      reset    = 1'b1;
      cycle();
      chk("t7.out_valid", a_out_valid, 0);
      chk("t7.in_ready", a_in_ready, 1);
      chk("t7.target", a_target, 0);
      chk("t7.pc_out", a_pc, 0);
      chk("t7.opcode", a_opcode, 0);
      reset = 1'b0;

      // random phase
      for (int i = 0; i < 600; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         reset       = ($urandom_range(0, 79) == 0);
         instruction = $urandom;
         pc_in       = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                   : $urandom;
         if ($urandom_range(0, 1) == 0) instruction = instruction & 32'hFF07_0707;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
